// File: rtl/roi_downsampler_if.sv
// ---------------------------------------------------------------------------
// roi_downsampler_if
// Bundles the control, pixel-stream and result-read signals of the ROI
// down-sampler. Clock and reset stay plain ports on the module.
//
//   iStart                 one-cycle pulse: latch bounds, arm next frame
//   iLeftBound/iRightBound ROI columns, inclusive (0..319)
//   iTopBound/iBotBound    ROI rows, inclusive (0..239)
//   iDATA/iDVAL/iFVAL      binary pixel, pixel valid, frame valid
//   iRdAddr/oRdData        row-major read port into the 28x28 result
//   oBusy/oDone            status
//
// master: the side that drives the stream (camera/host, testbench)
// slave : the down-sampler itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface roi_downsampler_if;
    logic       iStart;
    logic [8:0] iLeftBound;
    logic [8:0] iRightBound;
    logic [8:0] iTopBound;
    logic [8:0] iBotBound;
    logic       iDATA;
    logic       iDVAL;
    logic       iFVAL;
    logic [9:0] iRdAddr;
    logic       oRdData;
    logic       oBusy;
    logic       oDone;

    modport master (
        output iStart, iLeftBound, iRightBound, iTopBound, iBotBound,
        output iDATA, iDVAL, iFVAL, iRdAddr,
        input  oRdData, oBusy, oDone
    );

    modport slave (
        input  iStart, iLeftBound, iRightBound, iTopBound, iBotBound,
        input  iDATA, iDVAL, iFVAL, iRdAddr,
        output oRdData, oBusy, oDone
    );
endinterface

// File: rtl/roi_downsampler.sv
// ---------------------------------------------------------------------------
// roi_downsampler
// Captures one 320x240 binary frame and nearest-neighbour samples a
// rectangular region of interest down to a fixed 28x28 bit map.
//
// Ports:
//   iCLK  pixel clock, all state on the rising edge
//   iRST  asynchronous active-low reset
//   bus   roi_downsampler_if.slave (start/bounds, pixel stream, read port,
//         busy/done status)
//
// Flow: iStart latches (and sanitises) the bounds, a restoring divider
// computes the 8.8 fixed-point source step per output cell, then the block
// waits for the start of a fresh frame and writes one result bit whenever
// the incoming pixel coordinate hits the next sampling point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module roi_downsampler (
    input  logic             iCLK,
    input  logic             iRST,
    roi_downsampler_if.slave bus
);

    localparam int unsigned N_OUT    = 28;
    localparam int unsigned N_CELLS  = N_OUT * N_OUT;
    localparam logic [8:0]  MAX_COL  = 9'd319;
    localparam logic [8:0]  MAX_ROW  = 9'd239;
    // 17 dividend bits -> 17 restoring iterations, counted 0..16
    localparam logic [4:0]  DIV_LAST = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // latched ROI origin; right/bottom only matter through the step values
    logic [8:0]  left;
    logic [8:0]  top;

    // restoring dividers: quotient register starts as the dividend and the
    // quotient bits shift in from the right as the dividend shifts out
    logic [16:0] div_qx, div_qy;
    logic [4:0]  div_rx, div_ry;
    logic [4:0]  div_cnt;
    logic [16:0] div_qx_next, div_qy_next;
    logic [4:0]  div_rx_next, div_ry_next;
    logic [5:0]  trial_x, trial_y;

    logic [11:0] step_x, step_y;

    // capture position and 8.8 sampling accumulators
    logic [8:0]  col;
    logic [8:0]  row;
    logic [4:0]  out_col;
    logic [4:0]  out_row;
    logic [19:0] acc_x;
    logic [19:0] acc_y;

    logic [N_CELLS-1:0] result;

    // bound sanitising, evaluated on the iStart cycle
    logic [9:0]  right_min, bot_min;
    logic        bounds_bad;
    logic [8:0]  start_left, start_right, start_top, start_bot;
    logic [8:0]  start_width, start_height;

    // capture-side decode
    logic [12:0] col_target, row_target;
    logic        col_hit, row_hit, col_wrap, pix_hit, last_row_done;
    logic [9:0]  wr_addr;

    // -----------------------------------------------------------------------
    // Bounds check and full-frame substitution
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        right_min  = 10'(bus.iLeftBound) + 10'd27;
        bot_min    = 10'(bus.iTopBound) + 10'd27;
        bounds_bad = (10'(bus.iRightBound) < right_min) ||
                     (10'(bus.iBotBound) < bot_min) ||
                     (bus.iRightBound > MAX_COL) ||
                     (bus.iBotBound > MAX_ROW);
        start_left  = bus.iLeftBound;
        start_right = bus.iRightBound;
        start_top   = bus.iTopBound;
        start_bot   = bus.iBotBound;
        if (bounds_bad) begin
            start_left  = 9'd0;
            start_right = MAX_COL;
            start_top   = 9'd0;
            start_bot   = MAX_ROW;
        end
        // valid bounds guarantee right >= left, so no underflow; max is 320
        start_width  = start_right - start_left + 9'd1;
        start_height = start_bot - start_top + 9'd1;
    end

    // -----------------------------------------------------------------------
    // One restoring-division step for each axis (divisor is the constant 28)
    // -----------------------------------------------------------------------
    assign trial_x = {div_rx, div_qx[16]};
    assign trial_y = {div_ry, div_qy[16]};

    always_comb begin
        div_qx_next = {div_qx[15:0], 1'b0};
        div_rx_next = trial_x[4:0];
        div_qy_next = {div_qy[15:0], 1'b0};
        div_ry_next = trial_y[4:0];
        if (trial_x >= 6'd28) begin
            div_qx_next[0] = 1'b1;
            div_rx_next    = 5'(trial_x - 6'd28);
        end
        if (trial_y >= 6'd28) begin
            div_qy_next[0] = 1'b1;
            div_ry_next    = 5'(trial_y - 6'd28);
        end
    end

    // -----------------------------------------------------------------------
    // Sampling-point decode
    // -----------------------------------------------------------------------
    assign col_target    = 13'(left) + 13'(acc_x[19:8]);
    assign row_target    = 13'(top) + 13'(acc_y[19:8]);
    assign col_hit       = (13'(col) == col_target);
    assign row_hit       = (13'(row) == row_target);
    assign col_wrap      = (col == MAX_COL);
    assign pix_hit       = bus.iDVAL && row_hit && col_hit && (out_col < 5'(N_OUT));
    // the wrap of the 28th matched line completes the map
    assign last_row_done = bus.iDVAL && col_wrap && row_hit && (out_row == 5'(N_OUT - 1));
    assign wr_addr       = 10'(out_row) * 10'd28 + 10'(out_col);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and status outputs; iStart overrides everything,
    // including a coincident end-of-capture event
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        bus.oBusy  = 1'b0;
        bus.oDone  = 1'b0;

        if (bus.iStart) begin
            state_next = DIV;
        end else begin
            case (state)
                IDLE:      state_next = IDLE;
                DIV:       if (div_cnt == DIV_LAST) state_next = WAIT_LOW;
                WAIT_LOW:  if (!bus.iFVAL) state_next = WAIT_HIGH;
                WAIT_HIGH: if (bus.iFVAL) state_next = CAPTURE;
                CAPTURE:   if (!bus.iFVAL || last_row_done) state_next = DONE;
                DONE:      state_next = DONE;
                default:   state_next = IDLE;
            endcase
        end

        bus.oBusy = (state != IDLE) && (state != DONE);
        bus.oDone = (state == DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath: bounds, divider, counters, accumulators, result map
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!iRST) begin
            left    <= '0;
            top     <= '0;
            div_qx  <= '0;
            div_qy  <= '0;
            div_rx  <= '0;
            div_ry  <= '0;
            div_cnt <= '0;
            step_x  <= '0;
            step_y  <= '0;
            col     <= '0;
            row     <= '0;
            out_col <= '0;
            out_row <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            // NOTE: the result map is flops, not RAM, because reset and
            // iStart must clear all 784 bits in a single cycle.
            result  <= '0;
        end else if (bus.iStart) begin
            left    <= start_left;
            top     <= start_top;
            div_qx  <= {start_width, 8'd0};
            div_qy  <= {start_height, 8'd0};
            div_rx  <= '0;
            div_ry  <= '0;
            div_cnt <= '0;
            step_x  <= '0;
            step_y  <= '0;
            col     <= '0;
            row     <= '0;
            out_col <= '0;
            out_row <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            result  <= '0;
        end else begin
            case (state)
                DIV: begin
                    div_qx  <= div_qx_next;
                    div_qy  <= div_qy_next;
                    div_rx  <= div_rx_next;
                    div_ry  <= div_ry_next;
                    div_cnt <= div_cnt + 5'd1;
                    // quotient <= 2925 always fits the 12-bit step
                    if (div_cnt == DIV_LAST) begin
                        step_x <= div_qx_next[11:0];
                        step_y <= div_qy_next[11:0];
                    end
                end

                WAIT_HIGH: begin
                    if (bus.iFVAL) begin
                        col     <= '0;
                        row     <= '0;
                        out_col <= '0;
                        out_row <= '0;
                        acc_x   <= '0;
                        acc_y   <= '0;
                    end
                end

                CAPTURE: begin
                    if (bus.iDVAL) begin
                        if (pix_hit) begin
                            result[wr_addr] <= bus.iDATA;
                            out_col         <= out_col + 5'd1;
                            acc_x           <= acc_x + 20'(step_x);
                        end
                        if (col_wrap) begin
                            col <= '0;
                            row <= row + 9'd1;
                            // later assignments win over a write on col 319
                            if (row_hit) begin
                                out_row <= out_row + 5'd1;
                                acc_y   <= acc_y + 20'(step_y);
                                out_col <= '0;
                                acc_x   <= '0;
                            end
                        end else begin
                            col <= col + 9'd1;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read port: combinational, zero beyond the 784-cell map
    // -----------------------------------------------------------------------
    always_comb begin
        bus.oRdData = 1'b0;
        if (bus.iRdAddr < 10'(N_CELLS)) begin
            bus.oRdData = result[bus.iRdAddr];
        end
    end

endmodule

// File: tb/tb_roi_downsampler.sv
// ---------------------------------------------------------------------------
// tb_roi_downsampler
// Scoreboard bench for roi_downsampler. Each scenario pushes the expected
// 28x28 map (computed from the closed-form sampling formula) into a queue
// when it drives the frame, then reads the DUT map back and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_roi_downsampler;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    roi_downsampler_if bus ();

    roi_downsampler dut (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bus)
    );

    typedef struct {
        int   addr;
        logic val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // pattern 0 white, 1 white on even cols, 2 odd cols, 3 col 0 only, 4 hash
    function automatic logic pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return (c % 2) == 1;
            3:       return c == 0;
            default: return ((r * 3 + c * 5) % 7) < 3;
        endcase
    endfunction

    // expected map: output (r,j) samples source (top+r*sy/256, left+j*sx/256)
    // and is written only if that source row arrived before the frame ended
    task automatic push_model(input int l, input int rt, input int t, input int b,
                              input int pat, input int lines);
        int sx, sy, sr, sc;
        exp_t e;
        if (rt < l + 27 || b < t + 27 || rt > 319 || b > 239) begin
            l = 0; rt = 319; t = 0; b = 239;
        end
        sx = ((rt - l + 1) * 256) / 28;
        sy = ((b - t + 1) * 256) / 28;
        for (int r = 0; r < 28; r++) begin
            for (int j = 0; j < 28; j++) begin
                sr = t + (r * sy) / 256;
                sc = l + (j * sx) / 256;
                e.addr = r * 28 + j;
                e.val  = (sr < lines) ? pix(pat, sr, sc) : 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_zeros();
        exp_t e;
        for (int a = 0; a < 784; a++) begin
            e.addr = a;
            e.val  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_out_of_range();
        exp_t e;
        e.val = 1'b0;
        e.addr = 784;  exp_q.push_back(e);
        e.addr = 900;  exp_q.push_back(e);
        e.addr = 1023; exp_q.push_back(e);
    endtask

    task automatic read_cell(input int addr, output logic v);
        @(negedge clk);
        bus.iRdAddr = 10'(addr);
        #1;
        v = bus.oRdData;
    endtask

    task automatic start_capture(input int l, input int rt, input int t, input int b);
        @(negedge clk);
        bus.iLeftBound  = 9'(l);
        bus.iRightBound = 9'(rt);
        bus.iTopBound   = 9'(t);
        bus.iBotBound   = 9'(b);
        bus.iStart      = 1'b1;
        @(negedge clk);
        bus.iStart      = 1'b0;
    endtask

    // frame gap long enough for the divider, then FVAL high before line 0
    task automatic frame_open();
        bus.iFVAL = 1'b0;
        repeat (30) @(negedge clk);
        bus.iFVAL = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_close();
        @(negedge clk);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
    endtask

    task automatic drive_lines(input int pat, input int first_row, input int nlines);
        for (int r = first_row; r < first_row + nlines; r++) begin
            for (int c = 0; c < 320; c++) begin
                @(negedge clk);
                bus.iDVAL = 1'b1;
                bus.iDATA = pix(pat, r, c);
            end
            @(negedge clk);
            bus.iDVAL = 1'b0;
            bus.iDATA = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.oDone !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.oDone !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: oDone=%b after %0d cycles, required 1", name, bus.oDone, n);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        logic got;
        bus.iStart = 1'b0; bus.iDATA = 1'b0; bus.iDVAL = 1'b0; bus.iFVAL = 1'b0;
        bus.iLeftBound = '0; bus.iRightBound = '0; bus.iTopBound = '0; bus.iBotBound = '0;
        bus.iRdAddr = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b required 0", bus.oBusy); end
        n_checks++;
        if (bus.oDone !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b required 0", bus.oDone); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_zeros();
        push_out_of_range();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL reset cell %0d: got %b required %b", e.addr, got, e.val); end
        end
    endtask

    task automatic test_full_roi_fval_fall();
        exp_t e;
        logic got;
        push_model(0, 319, 0, 239, 0, 50);
        start_capture(0, 319, 0, 239);
        n_checks++;
        if (bus.oBusy !== 1'b1) begin n_fail++; $display("FAIL full busy_after_start: got %b required 1", bus.oBusy); end
        frame_open();
        drive_lines(0, 0, 50);
        frame_close();
        wait_done("full");
        n_checks++;
        if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL full busy_in_done: got %b required 0", bus.oBusy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL full cell %0d: got %b required %b", e.addr, got, e.val); end
        end
    endtask

    task automatic test_step512(input int pat, input string name);
        exp_t e;
        logic got;
        push_model(100, 155, 0, 55, pat, 56);
        push_out_of_range();
        start_capture(100, 155, 0, 55);
        frame_open();
        drive_lines(pat, 0, 56);
        frame_close();
        wait_done(name);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL %s cell %0d: got %b required %b", name, e.addr, got, e.val); end
        end
    endtask

    task automatic test_invalid_bounds();
        exp_t e;
        logic got;
        push_model(200, 210, 0, 239, 3, 20);
        start_capture(200, 210, 0, 239);
        frame_open();
        drive_lines(3, 0, 20);
        frame_close();
        wait_done("invalid");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL invalid cell %0d: got %b required %b", e.addr, got, e.val); end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        logic got;
        // ROI exactly 28 wide/high: the smallest legal size, step 256
        start_capture(0, 27, 0, 27);
        frame_open();
        drive_lines(4, 0, 10);
        start_capture(0, 27, 0, 27);
        repeat (25) @(negedge clk);
        n_checks++;
        if (bus.oBusy !== 1'b1) begin n_fail++; $display("FAIL restart busy: got %b required 1", bus.oBusy); end
        push_zeros();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL restart_clear cell %0d: got %b required %b", e.addr, got, e.val); end
        end
        n_checks++;
        if (bus.oBusy !== 1'b1 || bus.oDone !== 1'b0) begin
            n_fail++;
            $display("FAIL restart still_waiting: busy=%b done=%b required busy=1 done=0", bus.oBusy, bus.oDone);
        end
        push_model(0, 27, 0, 27, 4, 28);
        frame_close();
        frame_open();
        drive_lines(4, 0, 28);
        frame_close();
        wait_done("restart");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL restart cell %0d: got %b required %b", e.addr, got, e.val); end
        end
    endtask

    task automatic test_reset_mid_capture();
        exp_t e;
        logic got;
        start_capture(0, 319, 0, 239);
        frame_open();
        drive_lines(0, 0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid in_reset: busy=%b done=%b required 0 0", bus.oBusy, bus.oDone);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // rest of this frame plus a whole new frame, with no iStart
        drive_lines(0, 5, 5);
        frame_close();
        frame_open();
        drive_lines(0, 0, 5);
        frame_close();
        n_checks++;
        if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid idle_after: busy=%b done=%b required 0 0", bus.oBusy, bus.oDone);
        end
        push_zeros();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_cell(e.addr, got);
            n_checks++;
            if (got !== e.val) begin n_fail++; $display("FAIL rstmid cell %0d: got %b required %b", e.addr, got, e.val); end
        end
    endtask

    initial begin
        test_reset();
        test_full_roi_fval_fall();
        test_step512(1, "even");
        test_step512(2, "odd");
        test_invalid_bounds();
        test_restart();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/roi_downsampler.md
ROI_DOWNSAMPLER -- requirements
Module: roi_downsampler

Interface
REQ-001 SHALL have the ports below; one clock; reset is asynchronous and active-low.
REQ-002 iCLK  input  1  pixel clock; all state on rising edge.
REQ-003 iRST  input  1  asynchronous active-low reset.
REQ-004 iStart  input  1  one-cycle pulse; latch bounds, arm capture of the next frame.
REQ-005 iLeftBound, iRightBound  input  9 each  ROI columns, inclusive, 0..319.
REQ-006 iTopBound, iBotBound  input  9 each  ROI rows, inclusive, 0..239.
REQ-007 iDATA  input  1  binary pixel; 1 = white.
REQ-008 iDVAL  input  1  pixel valid; 320 valid pixels per line, 240 lines per frame.
REQ-009 iFVAL  input  1  frame valid; high for the whole frame.
REQ-010 iRdAddr  input  10  read address into the 28x28 result, row-major (row*28+col).
REQ-011 oRdData  output  1  result bit at iRdAddr, combinational; 0 for iRdAddr >= 784.
REQ-012 oBusy  output  1  high in any state other than IDLE or DONE.
REQ-013 oDone  output  1  high in DONE until the next iStart or reset.

Function
REQ-014 States SHALL be IDLE, DIV, WAIT_LOW, WAIT_HIGH, CAPTURE, DONE.
REQ-015 On iStart in any state, the block SHALL do all of the following:
- latch the bounds;
- clear all 784 result bits to 0;
- clear counters and accumulators;
- enter DIV.
REQ-016 Bounds SHALL be invalid if any of the following hold:
- right < left + 27;
- bot < top + 27;
- right > 319;
- bot > 239.
If invalid, the block SHALL substitute left=0, right=319, top=0, bot=239.
REQ-017 DIV SHALL compute step_x = floor((width*256)/28) and step_y = floor((height*256)/28), where width = right-left+1 and height = bot-top+1.
- Both steps SHALL be 12-bit unsigned.
- Both SHALL be computed by a sequential restoring divider.
- DIV SHALL take at most 40 cycles, then go to WAIT_LOW.
REQ-018 WAIT_LOW SHALL wait for iFVAL=0, then go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL wait for iFVAL=1, then go to CAPTURE with col=0, row=0, out_col=0, out_row=0, acc_x=0, acc_y=0.
REQ-020 In CAPTURE, each iDVAL=1 cycle SHALL advance col. Col SHALL wrap from 319 to 0, and the wrap SHALL increment row.
REQ-021 A pixel SHALL be written when all of the following hold:
- iDVAL=1;
- row == top + acc_y[19:8];
- col == left + acc_x[19:8];
- out_col < 28.
The write SHALL set result[out_row*28+out_col] = iDATA, then out_col += 1 and acc_x += step_x.
REQ-022 On a col wrap of a matched row, the block SHALL set out_row += 1, acc_y += step_y, out_col = 0, acc_x = 0.
REQ-023 Since step >= 256, at most one output cell SHALL map per source pixel and per line. Output col j SHALL sample source column left + floor(j*step_x/256).
REQ-024 CAPTURE SHALL go to DONE when out_row reaches 28, or when iFVAL falls, whichever is first.
- Unwritten cells SHALL stay 0.
- DONE SHALL be entered the cycle after the terminating event.
REQ-025 In DONE, the result SHALL be stable and iDATA/iDVAL SHALL be ignored.
REQ-026 If iStart and the terminating event coincide, iStart SHALL win and the state SHALL be DIV.
REQ-027 Accumulators SHALL be 20 bits wide and SHALL NOT overflow for any legal bounds.
REQ-028 iRdAddr SHALL be readable in every state; the value read during CAPTURE is partial.

Reset
REQ-029 On iRST=0, the block SHALL asynchronously do all of the following:
- state = IDLE;
- oDone = 0, oBusy = 0;
- all result bits = 0, so oRdData = 0;
- counters, accumulators, steps and latched bounds = 0.
REQ-030 Reset asserted mid-CAPTURE SHALL abandon the frame. After release, the block SHALL stay in IDLE until iStart.

Verification
REQ-031 Bounds 0/319/0/239 with an all-white frame -> step_x=2925, step_y=2194; all 784 reads = 1; oDone high.
REQ-032 Bounds left=100, right=155, top=50, bot=105 (step 512 both), with pixel white iff col even -> step_x = step_y = 512; output col j samples col 100+2j, which is always even; all 784 cells = 1. The same test with white iff col odd -> all cells = 0.
REQ-033 Bounds left=200, right=210 (invalid) with a frame white only in column 0 -> full-frame substitution; output column 0 = 1 in all 28 rows; all other cells = 0.
REQ-034 iFVAL falls after 100 lines with ROI 0..319 / 0..239 -> DONE entered; out_row 0..11 written; rows 12..27 = 0.
REQ-035 iStart reissued mid-CAPTURE -> result cleared; oBusy stays 1; the capture restarts on the following frame.
REQ-036 iRST pulsed mid-CAPTURE -> oDone=0, oBusy=0, all reads 0; no further writes until iStart.
